// File: rtl/puf_challenge_sequencer_if.sv
// puf_challenge_sequencer_if
//   Record stream from the challenge sequencer to the host-side collector.
//   A record transfers on a clock edge where resp_valid and resp_ready are
//   both high.
//
// Signals:
//   resp_valid  1   record available (driven by master)
//   resp_ready  1   collector accepts the record (driven by slave)
//   resp_data   16  {challenge[7:0], response[7:0]} (driven by master)
interface puf_challenge_sequencer_if;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;

  modport master (
    output resp_valid,
    output resp_data,
    input  resp_ready
  );

  modport slave (
    input  resp_valid,
    input  resp_data,
    output resp_ready
  );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
//   Drives a parallel RO-PUF array. For each challenge of a run it holds the
//   PUF in reset for RST_CYCLES cycles, releases it, waits for the all-done
//   flag (bounded by TIMEOUT), captures the 8-bit response and emits a
//   {challenge, response} record over a valid/ready handshake.
//
// Optional feature (macro PUF_MAJORITY_EN):
//   Each challenge is evaluated three times and the emitted response is the
//   bitwise majority of the three captures. A timed-out evaluation
//   contributes 8'h00. Without the macro only one evaluation is done and no
//   extra response storage exists.
//
// Ports:
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   start          in   1   one-cycle pulse, begins a run when idle
//   start_chal     in   8   first challenge of the run
//   puf_challenge  out  8   challenge applied to the PUF array
//   puf_reset      out  1   reset to the PUF counters and arbiters
//   puf_done       in   1   all-done from the PUF array
//   puf_response   in   8   response bits from the PUF array
//   resp           master modport: resp_valid / resp_ready / resp_data
//   busy           out  1   high from accepted start until back in IDLE
//   timeout_err    out  1   sticky done-timeout flag, cleared by next start
module puf_challenge_sequencer #(
  parameter int unsigned          NUM_CHAL   = 16,
  parameter int unsigned          RST_CYCLES = 4,
  parameter int unsigned          TIMEOUT_W  = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT    = 24'hFFFFFF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [7:0]                       start_chal,
  output logic [7:0]                       puf_challenge,
  output logic                             puf_reset,
  input  logic                             puf_done,
  input  logic [7:0]                       puf_response,
  puf_challenge_sequencer_if.master        resp,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int unsigned          RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0]     RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [8:0]           CHAL_LAST = 9'(NUM_CHAL - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_WAIT,
    S_CAP,
    S_OUT
  } state_t;

  state_t               state;
  logic [8:0]           chal_cnt;
  logic [RST_W-1:0]     rst_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 timed_out;
  logic                 resp_valid_q;
  logic [15:0]          resp_data_q;
  logic [7:0]           cap_resp;

`ifdef PUF_MAJORITY_EN
  logic [1:0] eval_cnt;
  logic [7:0] resp_a;
  logic [7:0] resp_b;

  function automatic logic [7:0] majority3(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction
`endif

  // A timed-out evaluation contributes an all-zero response.
  assign cap_resp = timed_out ? 8'h00 : puf_response;

  assign resp.resp_valid = resp_valid_q;
  assign resp.resp_data  = resp_data_q;

  // Sequencer FSM. The PUF response is sampled in CAP, one cycle after done
  // is seen, so the arbiter outputs have settled. puf_challenge only moves on
  // the edge entering RST, so it never changes while the PUF is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      puf_challenge <= 8'h00;
      puf_reset     <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 16'h0000;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      chal_cnt      <= 9'd0;
      rst_cnt       <= '0;
      tmo_cnt       <= '0;
      timed_out     <= 1'b0;
`ifdef PUF_MAJORITY_EN
      eval_cnt      <= 2'd0;
      resp_a        <= 8'h00;
      resp_b        <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          puf_reset <= 1'b1;
          if (start) begin
            puf_challenge <= start_chal;
            chal_cnt      <= 9'd0;
            timeout_err   <= 1'b0;
            busy          <= 1'b1;
            rst_cnt       <= '0;
`ifdef PUF_MAJORITY_EN
            eval_cnt      <= 2'd0;
`endif
            state         <= S_RST;
          end
        end

        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            puf_reset <= 1'b0;
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
            state     <= S_WAIT;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (puf_done) begin
            state <= S_CAP;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            timed_out   <= 1'b1;
            state       <= S_CAP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_CAP: begin
`ifdef PUF_MAJORITY_EN
          // First two evaluations are stored and the PUF is re-run on the
          // same challenge; the third produces the record.
          if (eval_cnt == 2'd2) begin
            resp_data_q  <= {puf_challenge, majority3(resp_a, resp_b, cap_resp)};
            resp_valid_q <= 1'b1;
            eval_cnt     <= 2'd0;
            state        <= S_OUT;
          end else begin
            if (eval_cnt == 2'd0) begin
              resp_a <= cap_resp;
            end else begin
              resp_b <= cap_resp;
            end
            eval_cnt  <= eval_cnt + 2'd1;
            puf_reset <= 1'b1;
            rst_cnt   <= '0;
            state     <= S_RST;
          end
`else
          resp_data_q  <= {puf_challenge, cap_resp};
          resp_valid_q <= 1'b1;
          state        <= S_OUT;
`endif
        end

        S_OUT: begin
          if (resp_valid_q && resp.resp_ready) begin
            resp_valid_q <= 1'b0;
            puf_reset    <= 1'b1;
            if (chal_cnt == CHAL_LAST) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              chal_cnt      <= chal_cnt + 9'd1;
              puf_challenge <= puf_challenge + 8'd1;
              rst_cnt       <= '0;
              state         <= S_RST;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          puf_reset <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb_puf_challenge_sequencer
//   Self-checking bench for puf_challenge_sequencer. A small PUF model raises
//   done DONE_DELAY cycles after puf_reset falls and answers ~challenge.
//   Expected records are queued when a run is started and popped when the
//   DUT transfers a record.
module tb_puf_challenge_sequencer;

  localparam int unsigned NUM_CHAL   = 3;
  localparam int unsigned RST_CYCLES = 4;
  localparam int unsigned TIMEOUT_W  = 24;
  localparam logic [23:0] TIMEOUT    = 24'd100;
  localparam int          DONE_DELAY = 50;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] start_chal;
  logic [7:0] puf_challenge;
  logic       puf_reset;
  logic       puf_done;
  logic [7:0] puf_response;
  logic       busy;
  logic       timeout_err;

  puf_challenge_sequencer_if rif ();

  puf_challenge_sequencer #(
    .NUM_CHAL   (NUM_CHAL),
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT_W  (TIMEOUT_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_chal    (start_chal),
    .puf_challenge (puf_challenge),
    .puf_reset     (puf_reset),
    .puf_done      (puf_done),
    .puf_response  (puf_response),
    .resp          (rif),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  int          num_checks = 0;
  int          num_errors = 0;
  logic [15:0] sb[$];
  bit          never_done = 0;
  bit          stall_mode = 0;
  int          wait_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PUF array model: done some cycles after release, response = ~challenge.
  assign puf_response = ~puf_challenge;

  always @(posedge clk or posedge reset) begin
    if (reset || puf_reset) begin
      wait_cnt <= 0;
      puf_done <= 1'b0;
    end else if (wait_cnt < DONE_DELAY) begin
      wait_cnt <= wait_cnt + 1;
    end else if (!never_done) begin
      puf_done <= 1'b1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Continuous monitor: record scoreboard, puf_reset window length,
  // challenge stability while the PUF runs, and no stretching of records.
  int          hi_len    = 0;
  int          valid_len = 0;
  logic        prev_rst  = 1'b1;
  logic [7:0]  prev_chal = 8'h00;
  logic [15:0] exp_rec;

  always @(negedge clk) begin
    if (reset) begin
      hi_len    = 0;
      valid_len = 0;
      prev_rst  = 1'b1;
    end else begin
      if (busy && puf_reset) begin
        hi_len++;
      end else begin
        if (hi_len != 0) check_output("rst_window", hi_len, RST_CYCLES);
        hi_len = 0;
      end
      if (!puf_reset && !prev_rst) check_output("chal_stable", puf_challenge, prev_chal);
      prev_rst  = puf_reset;
      prev_chal = puf_challenge;
      if (rif.resp_valid) valid_len++;
      if (rif.resp_valid && rif.resp_ready) begin
        check_output("sb_has_entry", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          exp_rec = sb.pop_front();
          check_output("record", rif.resp_data, exp_rec);
        end
        if (!stall_mode) check_output("no_stretch", valid_len, 1);
        valid_len = 0;
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] chal, input bit expect_timeout);
    logic [7:0] c;
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_chal = chal;
    for (int i = 0; i < NUM_CHAL; i++) begin
      c = chal + 8'(i);
      sb.push_back({c, expect_timeout ? 8'h00 : ~c});
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("busy_set", busy, 1);
    check_output("tmo_cleared", timeout_err, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, busy, 0);
    check_output("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int n;
    reset          = 1'b0;
    start          = 1'b0;
    start_chal     = 8'h00;
    rif.resp_ready = 1'b1;
    #2;
    reset = 1'b1;

    // Reset state, with start held high during reset
    start      = 1'b1;
    start_chal = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_puf_reset", puf_reset, 1);
    check_output("rst_valid", rif.resp_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_chal", puf_challenge, 8'h00);
    check_output("rst_data", rif.resp_data, 16'h0000);
    check_output("rst_tmo", timeout_err, 0);
    start = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("idle_busy", busy, 0);
    check_output("idle_puf_reset", puf_reset, 1);

    // Basic run: 10EF, 11EE, 12ED
    apply_stimulus(8'h10, 1'b0);
    wait_idle("run_10_done");

    // Challenge wrap: FF00, 00FF, 01FE
    apply_stimulus(8'hFF, 1'b0);
    wait_idle("run_ff_done");

    // Consumer stall on the first record
    stall_mode     = 1'b1;
    rif.resp_ready = 1'b0;
    apply_stimulus(8'h20, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rif.resp_valid && n < 1000);
    check_output("stall_valid_seen", rif.resp_valid, 1);
    for (int i = 0; i < 20; i++) begin
      check_output("stall_valid", rif.resp_valid, 1);
      check_output("stall_data", rif.resp_data, 16'h20DF);
      check_output("stall_puf_reset", puf_reset, 0);
      check_output("stall_chal", puf_challenge, 8'h20);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rif.resp_ready = 1'b1;
    wait_idle("run_stall_done");
    stall_mode = 1'b0;

    // Done never arrives: timeout after 100 WAIT cycles, run continues
    never_done = 1'b1;
    apply_stimulus(8'h30, 1'b1);
    n = 0;
    while (puf_reset && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!timeout_err && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_output("tmo_latency", n, 100);
    check_output("tmo_flag", timeout_err, 1);
    wait_idle("run_tmo_done");
    check_output("tmo_sticky", timeout_err, 1);
    never_done = 1'b0;
    apply_stimulus(8'h40, 1'b0);
    wait_idle("run_40_done");

    // Reset during WAIT of the second challenge
    apply_stimulus(8'h50, 1'b0);
    n = 0;
    while (!(puf_challenge == 8'h51 && !puf_reset) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("reach_second_wait", 32'(puf_challenge == 8'h51 && !puf_reset), 1);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("abort_puf_reset", puf_reset, 1);
    check_output("abort_valid", rif.resp_valid, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_chal", puf_challenge, 8'h00);
    check_output("abort_data", rif.resp_data, 16'h0000);
    check_output("abort_tmo", timeout_err, 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_stimulus(8'h60, 1'b0);
    wait_idle("run_60_done");

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
